monster_ctrl: RTL and testbench
===============================

Name: monster_ctrl

Overview:
- Game-tick scheduler for the monster sprite layer.
- On each game tick it walks all monster slots one per clock: moves each monster toward the hero, toggles its animation frame, detects hero collisions and spawns new monsters.
- It then commits one consistent snapshot of position, direction, frame and active flags for the VGA sprite selector and monster ROM address logic.
- Sits between the game-tick divider and the selector, alongside hero state.

Parameters:
- N_MON, 4, number of monster slots (1..8).
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- SPR, 16, sprite edge in pixels; used for clamping and collision.
- STEP, 2, pixels moved per tick.
- SPAWN_PERIOD, 64, ticks between spawn attempts (>=2).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-tick pulse, already synchronous to clk.
- game_en  in  1  ticks ignored while low; state is held.
- hero_x  in  10  hero top-left x.
- hero_y  in  10  hero top-left y.
- mon_x  out  10*N_MON  packed x per slot; slot i at [10i+9:10i].
- mon_y  out  10*N_MON  packed y per slot.
- mon_dir  out  2*N_MON  direction per slot: 0 up, 1 down, 2 left, 3 right (same encoding as hero state).
- mon_frame  out  N_MON  animation frame select (0 -> *_0 ROM, 1 -> *_1 ROM).
- mon_active  out  N_MON  slot visible.
- hit  out  1  one-cycle pulse in COMMIT if any collision occurred in this pass.
- hit_count  out  8  saturating collision counter.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; a tick was lost.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM=IDLE, spawn counter 0, pending=0, LFSR seed 8'hA5. mon_dir resets to 0 (up) for every slot.
- FSM sequence: IDLE -> UPDATE -> SPAWN -> COMMIT -> IDLE.
- Tick acceptance:
  - tick accepted in IDLE when game_en=1.
  - tick while busy sets pending; pending starts the next pass straight from COMMIT (COMMIT -> UPDATE).
  - tick while pending=1 sets overrun; the tick is dropped.
- UPDATE: index i runs 0..N_MON-1, one slot per clk. Only active slots change, in shadow registers; outputs do not change until COMMIT.
  - dx=hero_x-x, dy=hero_y-y (signed 11-bit).
  - Axis: the axis with larger |d| is moved; tie -> x axis; dx=dy=0 -> no move, dir unchanged.
  - Move size is min(STEP,|d|) toward the hero (no overshoot).
  - dir is set to match the move.
  - Result is clamped to [0,SCREEN_W-SPR] x [0,SCREEN_H-SPR].
  - frame toggles on every move.
  - Collision uses post-move position: |dx'|<SPR and |dy'|<SPR -> slot deactivated, hit flag set, hit_count+1 (saturates at 255; multiple collisions in one pass each count).
- SPAWN: 1 cycle.
  - Spawn counter increments per accepted tick.
  - At SPAWN_PERIOD-1 with a free slot: the lowest free index is activated, counter cleared.
  - Spawn corner comes from LFSR[1:0]: 0 (0,0), 1 (W-SPR,0), 2 (0,H-SPR), 3 (W-SPR,H-SPR).
  - Spawned monster: dir=1, frame=0. It is not moved and not collision-checked until the next pass.
  - No free slot: counter holds at SPAWN_PERIOD-1 and the spawn retries on every later tick.
- COMMIT: 1 cycle. Shadow registers are copied to outputs atomically; hit pulses if any collision occurred this pass.
- Latency: tick accepted in IDLE -> outputs updated N_MON+2 cycles later.
- LFSR: 8-bit, x^8+x^6+x^5+x^4+1, advances every clk.
- game_en falling mid-pass: the current pass completes; pending is cleared.

Optional Feature:
- MONSTER_WANDER_EN defined: each slot keeps a 2-bit move counter. Every 4th move it takes direction LFSR[3:2] instead of chasing. The step is clamped as usual and the collision check is unchanged.
- Not defined: pure chase as above; the counters and the LFSR[3:2] use are absent.

Decomposition:
- Shared package fury_pkg:
  - direction localparams DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - COORD_W=10.
  - default SCREEN_W/SCREEN_H/SPR.
  - monster FSM state enum.
- One sub-module: mon_lfsr (8-bit LFSR with async active-low reset, seed parameter).
- Per-slot step/clamp/collision logic is a function in fury_pkg; it is not a separate module.

Test Plan:
- Reset mid-pass: rst_n low during UPDATE -> all outputs 0, busy=0 immediately (no clk needed).
- Spawn and chase:
  - SPAWN_PERIOD=2, hero=(100,50), LFSR forced so corner=0.
  - 2 ticks -> slot0 active at (0,0), dir=1.
  - next tick -> slot0 at (2,0), dir=3, frame=1, updated exactly N_MON+2 cycles after the tick.
- No overshoot / clamp / tie:
  - monster (99,50), hero (100,50) -> x=100 after one tick.
  - hero (700,470) -> monster x stops at 624, y stops at 464.
  - tie dx=dy=10 -> x moves, dir=3.
- Collision: monster (120,100), hero (106,100) -> after tick, mon_active[i]=0, hit high exactly one cycle, hit_count=1. A 2-slot simultaneous collision -> hit_count=2.
- Full slots: all N_MON active, spawn due -> no spawn, counter holds. One slot frees via collision -> spawn occurs on the following tick into that lowest index.
- Tick overrun: ticks at cycles 0, 1, 2 -> second tick runs as a back-to-back pass, third tick dropped, overrun=1 and sticky until reset. With game_en=0, ticks cause no change.

Source files
------------

// File: rtl/fury_pkg.sv
// -----------------------------------------------------------------------------
// fury_pkg - shared definitions for the monster sprite layer.
//
// Contents:
//   COORD_W          coordinate width in pixels (10 bits)
//   DIR_*            direction encoding, shared with hero state
//   DEF_SCREEN_W/H   default visible area
//   DEF_SPR          default sprite edge
//   mon_state_e      monster scheduler FSM states
//   slot_res_t       result of one slot update
//   step_slot()      per-slot move / clamp / collision evaluation
// -----------------------------------------------------------------------------
package fury_pkg;

   localparam int COORD_W = 10;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;
   localparam int DEF_SPR      = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_SPAWN  = 2'd2,
      ST_COMMIT = 2'd3
   } mon_state_e;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [1:0]         dir;
      logic               frame;
      logic               moved;
      logic               hit;
   } slot_res_t;

   // One slot step toward the hero (or in force_dir when force_en), clamped to
   // [0,xmax] x [0,ymax]; the collision test uses the post-move position.
   // 12-bit signed intermediates leave headroom for x+step and negative x-step.
   function automatic slot_res_t step_slot(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input logic [1:0]         dir,
      input logic               frame,
      input logic [COORD_W-1:0] hx,
      input logic [COORD_W-1:0] hy,
      input logic               force_en,
      input logic [1:0]         force_dir,
      input logic signed [11:0] step,
      input logic signed [11:0] xmax,
      input logic signed [11:0] ymax,
      input logic signed [11:0] spr
   );
      slot_res_t          r;
      logic signed [11:0] dx, dy, adx, ady, mv, nx, ny;
      r.x     = x;
      r.y     = y;
      r.dir   = dir;
      r.frame = frame;
      r.moved = 1'b0;
      r.hit   = 1'b0;
      nx  = $signed({2'b00, x});
      ny  = $signed({2'b00, y});
      dx  = $signed({2'b00, hx}) - nx;
      dy  = $signed({2'b00, hy}) - ny;
      adx = dx[11] ? -dx : dx;
      ady = dy[11] ? -dy : dy;
      if (force_en) begin
         r.moved = 1'b1;
         r.dir   = force_dir;
         case (force_dir)
            DIR_UP:   ny = ny - step;
            DIR_DOWN: ny = ny + step;
            DIR_LEFT: nx = nx - step;
            default:  nx = nx + step;
         endcase
      end else if (dx != 12'sd0 || dy != 12'sd0) begin
         r.moved = 1'b1;
         // Larger distance wins; a tie goes to the x axis.
         if (adx >= ady) begin
            mv = (adx < step) ? adx : step;
            if (dx[11]) begin
               nx    = nx - mv;
               r.dir = DIR_LEFT;
            end else begin
               nx    = nx + mv;
               r.dir = DIR_RIGHT;
            end
         end else begin
            mv = (ady < step) ? ady : step;
            if (dy[11]) begin
               ny    = ny - mv;
               r.dir = DIR_UP;
            end else begin
               ny    = ny + mv;
               r.dir = DIR_DOWN;
            end
         end
      end
      if (nx[11])          nx = 12'sd0;
      else if (nx > xmax)  nx = xmax;
      if (ny[11])          ny = 12'sd0;
      else if (ny > ymax)  ny = ymax;
      if (r.moved) r.frame = ~frame;
      r.x = nx[COORD_W-1:0];
      r.y = ny[COORD_W-1:0];
      dx  = $signed({2'b00, hx}) - nx;
      dy  = $signed({2'b00, hy}) - ny;
      adx = dx[11] ? -dx : dx;
      ady = dy[11] ? -dy : dy;
      r.hit = (adx < spr) && (ady < spr);
      return r;
   endfunction

endpackage

// File: rtl/mon_lfsr.sv
// -----------------------------------------------------------------------------
// mon_lfsr - free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset, loads SEED
//   value  out  current LFSR state, advances every clock
// -----------------------------------------------------------------------------
module mon_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) value <= SEED;
      else        value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
   end

endmodule

// File: rtl/monster_ctrl.sv
// -----------------------------------------------------------------------------
// monster_ctrl - game-tick scheduler for the monster sprite layer.
//
// Each accepted tick walks all slots one per clock (UPDATE), runs one spawn
// attempt (SPAWN) and then publishes a consistent snapshot (COMMIT).
// Outputs change N_MON+2 clocks after the accepting tick edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              one-cycle game tick (synchronous)
//   game_en           ticks ignored while low
//   hero_x, hero_y    hero top-left position
//   mon_x, mon_y      packed 10-bit position per slot
//   mon_dir           packed 2-bit direction per slot
//   mon_frame         animation frame per slot
//   mon_active        slot visible
//   hit               one-cycle pulse with the snapshot if any collision occurred
//   hit_count         saturating collision counter
//   busy              scheduler not idle
//   overrun           sticky, a tick was dropped
//
// Build option: MONSTER_WANDER_EN - every 4th move of a slot takes a random
// direction from the LFSR instead of chasing the hero.
// -----------------------------------------------------------------------------
module monster_ctrl
   import fury_pkg::*;
#(
   parameter int N_MON        = 4,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int SPR          = DEF_SPR,
   parameter int STEP         = 2,
   parameter int SPAWN_PERIOD = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tick,
   input  logic                       game_en,
   input  logic [COORD_W-1:0]         hero_x,
   input  logic [COORD_W-1:0]         hero_y,
   output logic [COORD_W*N_MON-1:0]   mon_x,
   output logic [COORD_W*N_MON-1:0]   mon_y,
   output logic [2*N_MON-1:0]         mon_dir,
   output logic [N_MON-1:0]           mon_frame,
   output logic [N_MON-1:0]           mon_active,
   output logic                       hit,
   output logic [7:0]                 hit_count,
   output logic                       busy,
   output logic                       overrun
);

   localparam int IW = (N_MON > 1) ? $clog2(N_MON) : 1;
   localparam int CW = $clog2(SPAWN_PERIOD);

   localparam logic signed [11:0] STEP_S = 12'(STEP);
   localparam logic signed [11:0] XMAX_S = 12'(SCREEN_W - SPR);
   localparam logic signed [11:0] YMAX_S = 12'(SCREEN_H - SPR);
   localparam logic signed [11:0] SPR_S  = 12'(SPR);
   localparam logic [COORD_W-1:0] XMAX   = COORD_W'(SCREEN_W - SPR);
   localparam logic [COORD_W-1:0] YMAX   = COORD_W'(SCREEN_H - SPR);
   localparam logic [CW-1:0]      SP_LAST = CW'(SPAWN_PERIOD - 1);
   localparam logic [IW-1:0]      IDX_LAST = IW'(N_MON - 1);

   mon_state_e         state;
   logic [IW-1:0]      idx;
   logic               pending;
   logic [CW-1:0]      spawn_cnt;
   logic [7:0]         lfsr;

   // Working copy of every slot; only COMMIT makes it visible.
   logic [COORD_W-1:0] sh_x      [N_MON];
   logic [COORD_W-1:0] sh_y      [N_MON];
   logic [1:0]         sh_dir    [N_MON];
   logic               sh_frame  [N_MON];
   logic               sh_active [N_MON];
   logic               pass_hit;
   logic [7:0]         sh_hits;

   slot_res_t          res;
   logic               wander;
   logic [1:0]         wander_dir;
   logic               free_any;
   logic [IW-1:0]      free_idx;
   logic               spare_unused;

   mon_lfsr #(.SEED(8'hA5)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .value (lfsr)
   );

`ifdef MONSTER_WANDER_EN
   logic [1:0] move_cnt [N_MON];
   assign wander     = (move_cnt[idx] == 2'd3);
   assign wander_dir = lfsr[3:2];
`else
   assign wander     = 1'b0;
   assign wander_dir = 2'b00;
`endif

   // LFSR bits and result fields not consumed in every build configuration.
   assign spare_unused = ^{lfsr, res};

   assign busy = (state != ST_IDLE);

   always_comb begin
      res = step_slot(sh_x[idx], sh_y[idx], sh_dir[idx], sh_frame[idx],
                      hero_x, hero_y, wander, wander_dir,
                      STEP_S, XMAX_S, YMAX_S, SPR_S);
   end

   // Free slots are judged on the published flags, so a slot freed by a
   // collision in this pass is only refilled on a later pass.
   always_comb begin
      free_any = 1'b0;
      free_idx = '0;
      for (int i = N_MON - 1; i >= 0; i--) begin
         if (!mon_active[i]) begin
            free_any = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   // Control: sequencing, tick acceptance, pending / overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         idx     <= '0;
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (!game_en) begin
            pending <= 1'b0;
         end else if (tick && state != ST_IDLE) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (tick && game_en) begin
                  state <= ST_UPDATE;
                  idx   <= '0;
               end
            end
            ST_UPDATE: begin
               if (idx == IDX_LAST) state <= ST_SPAWN;
               else                 idx   <= idx + 1'b1;
            end
            ST_SPAWN: state <= ST_COMMIT;
            ST_COMMIT: begin
               // A tick landing exactly in COMMIT starts the next pass directly.
               if (game_en && (pending || tick)) begin
                  state   <= ST_UPDATE;
                  idx     <= '0;
                  pending <= 1'b0;
               end else begin
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: slot update, spawn, snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_MON; i++) begin
            sh_x[i]      <= '0;
            sh_y[i]      <= '0;
            sh_dir[i]    <= DIR_UP;
            sh_frame[i]  <= 1'b0;
            sh_active[i] <= 1'b0;
`ifdef MONSTER_WANDER_EN
            move_cnt[i]  <= 2'd0;
`endif
         end
         pass_hit   <= 1'b0;
         sh_hits    <= 8'd0;
         spawn_cnt  <= '0;
         mon_x      <= '0;
         mon_y      <= '0;
         mon_dir    <= '0;
         mon_frame  <= '0;
         mon_active <= '0;
         hit        <= 1'b0;
         hit_count  <= 8'd0;
      end else begin
         hit <= 1'b0;
         case (state)
            ST_UPDATE: begin
               if (sh_active[idx]) begin
                  sh_x[idx]     <= res.x;
                  sh_y[idx]     <= res.y;
                  sh_dir[idx]   <= res.dir;
                  sh_frame[idx] <= res.frame;
`ifdef MONSTER_WANDER_EN
                  if (res.moved) move_cnt[idx] <= move_cnt[idx] + 2'd1;
`endif
                  if (res.hit) begin
                     sh_active[idx] <= 1'b0;
                     pass_hit       <= 1'b1;
                     if (sh_hits != 8'hFF) sh_hits <= sh_hits + 8'd1;
                  end
               end
            end
            ST_SPAWN: begin
               // With no free slot the counter parks at its last value so the
               // spawn retries on every later pass.
               if (spawn_cnt == SP_LAST) begin
                  if (free_any) begin
                     sh_active[free_idx] <= 1'b1;
                     sh_x[free_idx]      <= lfsr[0] ? XMAX : '0;
                     sh_y[free_idx]      <= lfsr[1] ? YMAX : '0;
                     sh_dir[free_idx]    <= DIR_DOWN;
                     sh_frame[free_idx]  <= 1'b0;
                     spawn_cnt           <= '0;
                  end
               end else begin
                  spawn_cnt <= spawn_cnt + 1'b1;
               end
            end
            ST_COMMIT: begin
               for (int i = 0; i < N_MON; i++) begin
                  mon_x[COORD_W*i +: COORD_W] <= sh_x[i];
                  mon_y[COORD_W*i +: COORD_W] <= sh_y[i];
                  mon_dir[2*i +: 2]           <= sh_dir[i];
                  mon_frame[i]                <= sh_frame[i];
                  mon_active[i]               <= sh_active[i];
               end
               hit       <= pass_hit;
               hit_count <= sh_hits;
               pass_hit  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_monster_ctrl.sv
module tb_monster_ctrl;

   localparam int N    = 4;
   localparam int SP   = 2;
   localparam int W    = 640;
   localparam int H    = 480;
   localparam int SPR  = 16;
   localparam int STEP = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           tick = 1'b0;
   logic           game_en = 1'b0;
   logic [9:0]     hero_x = 10'd100;
   logic [9:0]     hero_y = 10'd50;
   logic [10*N-1:0] mon_x, mon_y;
   logic [2*N-1:0] mon_dir;
   logic [N-1:0]   mon_frame, mon_active;
   logic           hit, busy, overrun;
   logic [7:0]     hit_count;

   monster_ctrl #(.N_MON(N), .STEP(STEP), .SPAWN_PERIOD(SP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .game_en    (game_en),
      .hero_x     (hero_x),
      .hero_y     (hero_y),
      .mon_x      (mon_x),
      .mon_y      (mon_y),
      .mon_dir    (mon_dir),
      .mon_frame  (mon_frame),
      .mon_active (mon_active),
      .hit        (hit),
      .hit_count  (hit_count),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // Reference LFSR: new bit is the parity of taps 8,6,5,4.
   logic [7:0] ref_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ref_lfsr <= 8'hA5;
      else        ref_lfsr <= {ref_lfsr[6:0], ^(ref_lfsr & 8'b1011_1000)};
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   int m_x[N], m_y[N], m_dir[N], m_fr[N], m_act[N];
   int m_cnt = 0, m_hits = 0;
   bit m_ovr = 1'b0;
   logic [10*N-1:0] exp_x = '0, exp_y = '0;
   logic [2*N-1:0]  exp_dir = '0;
   logic [N-1:0]    exp_fr = '0, exp_act = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_fr[i] = 0; m_act[i] = 0;
      end
      m_cnt = 0; m_hits = 0; m_ovr = 1'b0;
      exp_x = '0; exp_y = '0; exp_dir = '0; exp_fr = '0; exp_act = '0;
   endtask

   task automatic build_exp();
      for (int i = 0; i < N; i++) begin
         exp_x[10*i +: 10] = 10'(m_x[i]);
         exp_y[10*i +: 10] = 10'(m_y[i]);
         exp_dir[2*i +: 2] = 2'(m_dir[i]);
         exp_fr[i]         = m_fr[i][0];
         exp_act[i]        = m_act[i][0];
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0)  return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // One whole pass: chase every active slot, then one spawn attempt.
   task automatic model_pass(input logic [7:0] sl, output bit ph);
      int act0[N];
      int hx, hy, dx, dy, mv, f;
      hx = int'(hero_x);
      hy = int'(hero_y);
      ph = 1'b0;
      act0 = m_act;
      for (int i = 0; i < N; i++) begin
         if (m_act[i] != 0) begin
            dx = hx - m_x[i];
            dy = hy - m_y[i];
            if (dx != 0 || dy != 0) begin
               if (iabs(dx) >= iabs(dy)) begin
                  mv = (iabs(dx) < STEP) ? iabs(dx) : STEP;
                  m_x[i]   = m_x[i] + ((dx > 0) ? mv : -mv);
                  m_dir[i] = (dx > 0) ? 3 : 2;
               end else begin
                  mv = (iabs(dy) < STEP) ? iabs(dy) : STEP;
                  m_y[i]   = m_y[i] + ((dy > 0) ? mv : -mv);
                  m_dir[i] = (dy > 0) ? 1 : 0;
               end
               m_x[i]  = clampi(m_x[i], W - SPR);
               m_y[i]  = clampi(m_y[i], H - SPR);
               m_fr[i] = 1 - m_fr[i];
            end
            if (iabs(hx - m_x[i]) < SPR && iabs(hy - m_y[i]) < SPR) begin
               m_act[i] = 0;
               ph = 1'b1;
               if (m_hits < 255) m_hits++;
            end
         end
      end
      if (m_cnt == SP - 1) begin
         f = -1;
         for (int i = N - 1; i >= 0; i--) if (act0[i] == 0) f = i;
         if (f >= 0) begin
            m_act[f] = 1;
            m_x[f]   = sl[0] ? (W - SPR) : 0;
            m_y[f]   = sl[1] ? (H - SPR) : 0;
            m_dir[f] = 1;
            m_fr[f]  = 0;
            m_cnt    = 0;
         end
      end else begin
         m_cnt++;
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_x"},   64'(mon_x),      64'(exp_x));
      chk({tag, "_y"},   64'(mon_y),      64'(exp_y));
      chk({tag, "_dir"}, 64'(mon_dir),    64'(exp_dir));
      chk({tag, "_frm"}, 64'(mon_frame),  64'(exp_fr));
      chk({tag, "_act"}, 64'(mon_active), 64'(exp_act));
   endtask

   // nt ticks on consecutive cycles starting from IDLE; drop lowers game_en
   // after the second tick, which must cancel the queued pass.
   task automatic do_ticks(input int nt, input bit drop);
      int passes, total, base;
      bit ph [2];
      passes = (drop || nt < 2) ? 1 : 2;
      total  = passes * (N + 2);
      ph[0] = 1'b0; ph[1] = 1'b0;
      if (nt >= 3 && !drop) m_ovr = 1'b1;
      @(negedge clk);
      game_en = 1'b1;
      tick = 1'b1;
      @(posedge clk); #1;
      chk("busy_start", 64'(busy), 64'd1);
      for (int k = 1; k <= total; k++) begin
         tick = (k < nt);
         if (drop && k == 2) game_en = 1'b0;
         @(posedge clk); #1;
         for (int p = 0; p < passes; p++) begin
            base = p * (N + 2);
            if (k == base + N)     model_pass(ref_lfsr, ph[p]);
            if (k == base + N + 1) chk_outputs("hold");
            if (k == base + N + 2) begin
               build_exp();
               chk_outputs("commit");
               chk("hit_pulse", 64'(hit), 64'(ph[p]));
               chk("hit_count", 64'(hit_count), 64'(m_hits));
            end
         end
      end
      tick = 1'b0;
      chk("busy_end", 64'(busy), 64'd0);
      chk("overrun", 64'(overrun), 64'(m_ovr));
      @(posedge clk); #1;
      chk("hit_clear", 64'(hit), 64'd0);
      game_en = 1'b1;
   endtask

   task automatic disabled_ticks();
      @(negedge clk);
      game_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1;
         @(negedge clk);
      end
      tick = 1'b0;
      repeat (N + 3) @(negedge clk);
      chk("dis_busy", 64'(busy), 64'd0);
      chk("dis_ovr", 64'(overrun), 64'(m_ovr));
      chk_outputs("dis");
      game_en = 1'b1;
   endtask

   task automatic reset_mid_pass();
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      model_clear();
      chk_outputs("rst");
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_hit", 64'(hit), 64'd0);
      chk("rst_hcnt", 64'(hit_count), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic pick_hero();
      int act_list[$];
      int r, j, hx, hy;
      for (int i = 0; i < N; i++) if (m_act[i] != 0) act_list.push_back(i);
      r = int'($urandom_range(0, 9));
      if (act_list.size() > 0 && r < 5) begin
         j  = act_list[$urandom_range(0, act_list.size() - 1)];
         hx = m_x[j] + int'($urandom_range(0, 40)) - 20;
         hy = m_y[j] + int'($urandom_range(0, 40)) - 20;
      end else if (act_list.size() > 0 && r == 5) begin
         j  = act_list[$urandom_range(0, act_list.size() - 1)];
         hx = m_x[j] + 10;
         hy = m_y[j] + 10;
      end else if (r == 6) begin
         hx = 700;
         hy = 470;
      end else begin
         hx = int'($urandom_range(0, 700));
         hy = int'($urandom_range(0, 520));
      end
      hero_x = 10'(clampi(hx, 1023));
      hero_y = 10'(clampi(hy, 1023));
   endtask

   initial begin
      int r;
      model_clear();
      #12;
      chk_outputs("reset");
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hcnt", 64'(hit_count), 64'd0);
      chk("reset_ovr", 64'(overrun), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      game_en = 1'b1;

      // Spawn then chase from a fixed hero position.
      hero_x = 10'd100;
      hero_y = 10'd50;
      for (int t = 0; t < 3; t++) do_ticks(1, 1'b0);

      // Back-to-back pass plus a dropped tick.
      do_ticks(3, 1'b0);
      disabled_ticks();

      for (int it = 0; it < 160; it++) begin
         pick_hero();
         r = int'($urandom_range(0, 19));
         if (r == 0)      do_ticks(3, 1'b0);
         else if (r == 1) do_ticks(2, 1'b0);
         else if (r == 2) do_ticks(2, 1'b1);
         else if (r == 3) do_ticks(3, 1'b1);
         else if (r == 4) disabled_ticks();
         else             do_ticks(1, 1'b0);
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
         if (it == 110) reset_mid_pass();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
